cla_pipe_addsub: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor for the datapath ALU.
- Operands are split into GROUP-bit lookahead slices. A register boundary sits after every GROUPS_PER_STAGE slices, and the ripple carry crosses each boundary.
- Valid/ready handshakes on input and output let the ALU and writeback path stall it.
- Adds subtract, carry-in and flag generation (C, V, Z, N), which the fixed 8-bit adder lacks.

---
 rtl/cla_pipe_addsub.sv | 217 +++++++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub
//   Pipelined carry-lookahead adder/subtractor with valid/ready flow control
//   and C/V/Z/N flag generation for the datapath ALU.
//
//   The operand word is cut into GROUP-bit lookahead slices. Each pipeline
//   stage evaluates GROUPS_PER_STAGE slices and rippling carries between
//   them. The carry out of a stage is registered and feeds the next stage.
//   An entry register holds the conditioned operands, so a beat accepted at
//   edge N is presented at the output after edge N+DEPTH.
//
//   Ports
//     CLK        clock, all state on the rising edge
//     reset      synchronous, active-high
//     in_valid   operand beat valid
//     in_ready   beat accepted this cycle when in_valid is also high
//     a, b       operands (WIDTH bits)
//     sub        1: A - B, 0: A + B
//     cin        carry-in, only used when use_cin = 1
//     use_cin    1: chain cin (ADC/SBC), 0: default carry (0 add, 1 sub)
//     out_valid  result valid, held until out_ready
//     out_ready  consumer takes the result
//     sum        result modulo 2^WIDTH
//     cout       carry out of the MSB (subtract: 1 = no borrow)
//     ovf        signed overflow
//     zero       result is zero (only asserted with out_valid)
//     neg        result MSB
module cla_pipe_addsub #(
    parameter int WIDTH            = 16,
    parameter int GROUP            = 4,
    parameter int GROUPS_PER_STAGE = 1
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    input  logic             use_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int SW    = GROUP * GROUPS_PER_STAGE;
    localparam int DEPTH = (SW > 0) ? (WIDTH / SW) : 1;

    if (GROUP < 1 || GROUPS_PER_STAGE < 1 || WIDTH < SW || (WIDTH % SW) != 0) begin : g_param_check
        $error("cla_pipe_addsub: WIDTH must be a non-zero multiple of GROUP*GROUPS_PER_STAGE");
    end

    // One GROUP-bit lookahead slice. Each carry is a flat OR of the generate
    // terms below it, each masked by the propagates in between, plus the
    // slice carry-in masked by all lower propagates; no carry waits on
    // another carry inside the slice. Returns {carry_out, sum}.
    function automatic logic [GROUP:0] cla_group(
        input logic [GROUP-1:0] x,
        input logic [GROUP-1:0] y,
        input logic             c0
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             term;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            term = c0;
            for (int m = 0; m <= i; m++) begin
                term = term & p[m];
            end
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    // Single global advance enable: the whole pipe moves or the whole pipe
    // holds. Bubbles are kept, which keeps the control trivial.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---- entry register: conditioned operands (B inverted for subtract) ----
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             c_p0;
    logic             vld_p0;

    always_ff @(posedge CLK) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            a_p0   <= '0;
            b_p0   <= '0;
            c_p0   <= 1'b0;
        end else if (en) begin
            vld_p0 <= in_valid;
            a_p0   <= a;
            b_p0   <= sub ? ~b : b;
            c_p0   <= use_cin ? cin : sub;
        end
    end

    // Stage k consumes the low SW bits of its operand inputs, appends its
    // slice to the finished lower sum, and forwards only the operand bits
    // that later stages still need.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        localparam int OW = (DEPTH - k) * SW;

        logic [OW-1:0]       op_a;
        logic [OW-1:0]       op_b;
        logic                c_in;
        logic                v_in;
        logic [SW-1:0]       s_slice;
        logic                c_out;
        logic [GROUP:0]      r_grp;
        logic                c_rip;
        logic [(k+1)*SW-1:0] sum_nxt;
        logic [(k+1)*SW-1:0] sum_p;
        logic                cy_p;
        logic                vld_p;

        if (k == 0) begin : g_src
            assign op_a = a_p0;
            assign op_b = b_p0;
            assign c_in = c_p0;
            assign v_in = vld_p0;
        end else begin : g_src
            assign op_a = g_stage[k-1].g_fwd.a_p;
            assign op_b = g_stage[k-1].g_fwd.b_p;
            assign c_in = g_stage[k-1].cy_p;
            assign v_in = g_stage[k-1].vld_p;
        end

        // Lookahead inside each slice, ripple between the slices of a stage.
        always_comb begin
            s_slice = '0;
            r_grp   = '0;
            c_rip   = c_in;
            for (int gi = 0; gi < GROUPS_PER_STAGE; gi++) begin
                r_grp = cla_group(op_a[gi*GROUP +: GROUP], op_b[gi*GROUP +: GROUP], c_rip);
                s_slice[gi*GROUP +: GROUP] = r_grp[GROUP-1:0];
                c_rip = r_grp[GROUP];
            end
            c_out = c_rip;
        end

        if (k == 0) begin : g_acc
            assign sum_nxt = s_slice;
        end else begin : g_acc
            assign sum_nxt = {s_slice, g_stage[k-1].sum_p};
        end

        // ---- stage k register boundary ----
        always_ff @(posedge CLK) begin
            if (reset) begin
                vld_p <= 1'b0;
                cy_p  <= 1'b0;
                sum_p <= '0;
            end else if (en) begin
                vld_p <= v_in;
                cy_p  <= c_out;
                sum_p <= sum_nxt;
            end
        end

        if (k < DEPTH - 1) begin : g_fwd
            logic [OW-SW-1:0] a_p;
            logic [OW-SW-1:0] b_p;

            always_ff @(posedge CLK) begin
                if (reset) begin
                    a_p <= '0;
                    b_p <= '0;
                end else if (en) begin
                    a_p <= op_a[OW-1:SW];
                    b_p <= op_b[OW-1:SW];
                end
            end
        end else begin : g_last
            // The carry into the MSB is recovered from the MSB sum bit
            // (s = a ^ b' ^ c_msb), so overflow is c_msb ^ carry_out.
            logic ovf_p;

            always_ff @(posedge CLK) begin
                if (reset) begin
                    ovf_p <= 1'b0;
                end else if (en) begin
                    ovf_p <= c_out ^ op_a[OW-1] ^ op_b[OW-1] ^ s_slice[SW-1];
                end
            end
        end
    end

    assign out_valid = g_stage[DEPTH-1].vld_p;
    assign sum       = g_stage[DEPTH-1].sum_p;
    assign cout      = g_stage[DEPTH-1].cy_p;
    assign ovf       = g_stage[DEPTH-1].g_last.ovf_p;
    assign neg       = sum[WIDTH-1];
    // Gated with out_valid so the idle/reset output reads zero = 0 even
    // though the cleared sum register is all zeros.
    assign zero      = out_valid && (sum == '0);

endmodule

// File: tb/tb_cla_pipe_addsub.sv
`timescale 1ns/1ps
module tb_cla_pipe_addsub;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        reset, in_valid, out_ready, sub, cin, use_cin;
    logic [15:0] a, b, sum;
    logic        in_ready, out_valid, cout, ovf, zero, neg;
    logic [31:0] a32, b32, sum32;
    logic        in_ready32, out_valid32, cout32, ovf32, zero32, neg32;

    cla_pipe_addsub dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .use_cin(use_cin),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    cla_pipe_addsub #(.WIDTH(32), .GROUP(4), .GROUPS_PER_STAGE(2)) dut32 (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
        .a(a32), .b(b32), .sub(sub), .cin(cin), .use_cin(use_cin),
        .out_valid(out_valid32), .out_ready(out_ready), .sum(sum32),
        .cout(cout32), .ovf(ovf32), .zero(zero32), .neg(neg32)
    );

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic        ci;
        logic        uc;
        logic [15:0] es;
        logic        ec;
        logic        ev;
        logic        ez;
        logic        en;
    } vec_t;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Reference: the arithmetic meaning of the operation, in wide integers.
    function automatic res_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input logic s, input logic ci, input logic uc);
        res_t   r;
        longint m, ux, uy, sx, sy, c0, ures, sres;
        m    = longint'(1) << w;
        ux   = longint'({32'h0, x}) & (m - 1);
        uy   = longint'({32'h0, y}) & (m - 1);
        sx   = (ux >= m / 2) ? ux - m : ux;
        sy   = (uy >= m / 2) ? uy - m : uy;
        c0   = (uc ? ci : s) ? 1 : 0;
        if (s) begin
            ures = ux - uy - 1 + c0 + m;
            sres = sx - sy - 1 + c0;
        end else begin
            ures = ux + uy + c0;
            sres = sx + sy + c0;
        end
        r.s = 32'(ures & (m - 1));
        r.c = (ures >= m);
        r.v = (sres >= m / 2) || (sres < -(m / 2));
        r.z = (r.s == 32'h0);
        r.n = ures[w-1];
        return r;
    endfunction

    function automatic res_t get16();
        return {16'h0, sum, cout, ovf, zero, neg};
    endfunction

    function automatic res_t get32();
        return {sum32, cout32, ovf32, zero32, neg32};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        a = 16'h0; b = 16'h0; a32 = 32'h0; b32 = 32'h0;
        sub = 1'b0; cin = 1'b0; use_cin = 1'b0;
    endtask

    // Present one beat to both DUTs into an empty pipe and wait for it.
    task automatic one_beat(input logic [15:0] ia, input logic [15:0] ib,
                            input logic [31:0] ia32, input logic [31:0] ib32,
                            input logic is, input logic ic, input logic iu,
                            output res_t r16, output res_t r32, output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = ia; b = ib; a32 = ia32; b32 = ib32;
        sub = is; cin = ic; use_cin = iu;
        #1;
        check("beat_in_ready", 64'(in_ready & in_ready32), 64'(1));
        tick();
        idle_inputs();
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("beat_valid32_aligned", 64'(out_valid32), 64'(1));
        r16 = get16();
        r32 = get32();
        tick();
    endtask

    vec_t vt[8];

    initial begin
        res_t r16, r32, e, prev;
        int   lat, nsent, nrecv, stall, seen;
        logic prev_stall;
        res_t q16[$];
        res_t q32[$];

        vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[4] = '{16'h0010, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[6] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[7] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset then idle.
        idle_inputs();
        out_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("idle16_c%0d", i),
                  64'({out_valid, in_ready, sum, cout, ovf, zero, neg}), 64'({1'b0, 1'b1, 20'h0}));
            check($sformatf("idle32_c%0d", i),
                  64'({out_valid32, in_ready32, sum32, cout32, ovf32, zero32, neg32}), 64'({1'b0, 1'b1, 36'h0}));
            tick();
        end

        // Directed vectors; the 32-bit instance gets random upper halves.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] xa, xb;
            xa = {16'($urandom), vt[i].a};
            xb = {16'($urandom), vt[i].b};
            one_beat(vt[i].a, vt[i].b, xa, xb, vt[i].s, vt[i].ci, vt[i].uc, r16, r32, lat);
            e = {16'h0, vt[i].es, vt[i].ec, vt[i].ev, vt[i].ez, vt[i].en};
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(4));
            check($sformatf("vec%0d_res16", i), 64'(r16), 64'(e));
            check($sformatf("vec%0d_res32", i), 64'(r32), 64'(model(32, xa, xb, vt[i].s, vt[i].ci, vt[i].uc)));
        end

        // 32-bit add and wrap cases.
        one_beat(16'h1234, 16'h4321, 32'h1234_1234, 32'h4321_4321, 1'b0, 1'b0, 1'b0, r16, r32, lat);
        check("w32_add_latency", 64'(lat), 64'(4));
        check("w32_add", 64'(r32), 64'({32'h5555_5555, 4'b0000}));
        one_beat(16'hFFFF, 16'h0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, r16, r32, lat);
        check("w32_wrap", 64'(r32), 64'({32'h0, 4'b1010}));
        one_beat(16'h7FFF, 16'h0001, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, r16, r32, lat);
        check("w32_ovf", 64'(r32), 64'({32'h8000_0000, 4'b0101}));

        // Back-to-back stream of 8 beats with a 3-cycle stall on the first result.
        nsent = 0; nrecv = 0; stall = 0;
        for (int cyc = 0; cyc < 100 && nrecv < 8; cyc++) begin
            in_valid = (nsent < 8);
            a   = 16'(nsent + 1); b   = 16'(nsent + 1);
            a32 = 32'(nsent + 1); b32 = 32'(nsent + 1);
            out_ready = !(out_valid && stall < 3);
            #1;
            if (out_valid && !out_ready) begin
                check($sformatf("bp_in_ready_s%0d", stall), 64'(in_ready), 64'(0));
                check($sformatf("bp_hold_s%0d", stall), 64'(sum), 64'(16'h0002));
                stall++;
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp_sum16_%0d", nrecv), 64'(sum), 64'(2 * (nrecv + 1)));
                check($sformatf("bp_sum32_%0d", nrecv), 64'(sum32), 64'(2 * (nrecv + 1)));
                nrecv++;
            end
            if (in_valid && in_ready) nsent++;
            tick();
        end
        check("bp_received", 64'(nrecv), 64'(8));
        check("bp_stalls", 64'(stall), 64'(3));
        idle_inputs();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Reset while beats are in flight; a beat offered during reset is dropped.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'(16'h0100 + i); b = 16'h0001; a32 = 32'(i); b32 = 32'h1;
            tick();
        end
        reset = 1'b1;
        a = 16'h0AAA; b = 16'h0AAA;
        tick();
        reset = 1'b0;
        idle_inputs();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid || out_valid32) seen++;
            tick();
        end
        check("rst_flush", 64'(seen), 64'(0));
        one_beat(16'h0003, 16'h0004, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b0, r16, r32, lat);
        check("rst_fresh_latency", 64'(lat), 64'(4));
        check("rst_fresh_sum", 64'(r16), 64'({32'h7, 4'b0000}));

        // Randomized traffic with random backpressure, scored against the model.
        prev_stall = 1'b0;
        prev = '0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            in_valid  = (cyc < 380) && ($urandom_range(0, 3) != 0);
            out_ready = (cyc >= 380) || ($urandom_range(0, 3) != 0);
            a   = 16'($urandom); b   = 16'($urandom);
            a32 = $urandom;      b32 = $urandom;
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            use_cin = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                check("rand_stall_valid", 64'(out_valid), 64'(1));
                check("rand_stall_hold", 64'(get16()), 64'(prev));
            end
            if (out_valid && out_ready) begin
                if (q16.size() == 0) check("rand_extra16", 64'(1), 64'(0));
                else check("rand16", 64'(get16()), 64'(q16.pop_front()));
            end
            if (out_valid32 && out_ready) begin
                if (q32.size() == 0) check("rand_extra32", 64'(1), 64'(0));
                else check("rand32", 64'(get32()), 64'(q32.pop_front()));
            end
            if (in_valid && in_ready)
                q16.push_back(model(16, {16'h0, a}, {16'h0, b}, sub, cin, use_cin));
            if (in_valid && in_ready32)
                q32.push_back(model(32, a32, b32, sub, cin, use_cin));
            prev_stall = out_valid && !out_ready;
            prev = get16();
            tick();
        end
        check("rand_drain16", 64'(q16.size()), 64'(0));
        check("rand_drain32", 64'(q32.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
